uart_loader: RTL and testbench

//  Bus initiator fed from a serial line: deserialises a UART byte stream into

---
 rtl/uart_loader_pkg.sv | 20 ++
 rtl/uart_loader_rx_byte.sv | 83 ++++++++
 rtl/uart_loader.sv | 128 ++++++++++++
 tb/tb_uart_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: byte codes, state encodings and defaults shared by the UART program loader
package uart_loader_pkg;
    localparam logic [7:0] loader_sync_byte = 8'hA5;
    localparam logic [7:0] loader_cmd_write = 8'h01;
    localparam logic [7:0] loader_cmd_go    = 8'h02;
    localparam int clk_per_bit_default = 868;

    typedef enum logic [2:0] {
        S_SYNC,
        S_CMD,
        S_ADDR,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_BUS
    } loader_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_loader_rx_byte.sv
// uart_rx_byte: synchronised 8N1 receiver producing one strobe per good byte and a pulse per bad stop bit
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLK_PER_BIT = clk_per_bit_default
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       stop_err
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] last_cnt = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] half_cnt = CW'(CLK_PER_BIT / 2 - 1);

    rx_state_t state_q, state_d;
    logic [2:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic stb_q, stb_d, err_q, err_d, rx_s;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
    assign rx_s     = sync_q[1];
    assign rx_byte  = sh_q;
    assign byte_stb = stb_q;
    assign stop_err = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[1:0], rx};
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (sync_q[2] && !rx_s) state_d = RX_START;
            end
            RX_START: if (cnt_q == half_cnt) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == last_cnt) begin
                cnt_d   = '0;
                sh_d    = {rx_s, sh_q[7:1]};
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (cnt_q == last_cnt) begin
                stb_d   = rx_s;
                err_d   = !rx_s;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: turns A5-framed UART packets into 32-bit bus writes and a sticky boot_done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on WRITE packets.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_PER_BIT = clk_per_bit_default
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        boot_done,
    output logic        frame_err
);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t data_done_state = S_CHK;
`else
    localparam loader_state_t data_done_state = S_BUS;
`endif

    loader_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [7:0] hold_q, hold_d;
    logic hold_vld_q, hold_vld_d, boot_q, boot_d, ferr_q, ferr_d;
    logic [7:0] rx_byte;
    logic byte_stb, stop_err, consume, overrun, unused_rdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
`endif

    uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clock    (clock),
        .reset    (reset),
        .rx       (uart_rx),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .stop_err (stop_err)
    );

    assign mem_valid    = state_q == S_BUS;
    assign mem_instr    = 1'b0;
    assign mem_addr     = addr_q;
    assign mem_wdata    = data_q;
    assign mem_wstrb    = {4{mem_valid}};
    assign boot_done    = boot_q;
    assign frame_err    = ferr_q;
    assign unused_rdata = ^mem_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_SYNC;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            boot_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            boot_q     <= boot_d;
            ferr_q     <= ferr_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) chk_q <= '0;
        else chk_q <= chk_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        boot_d     = boot_q;
        consume    = hold_vld_q && state_q != S_BUS;
        overrun    = byte_stb && hold_vld_q && !consume;
        hold_d     = (byte_stb && !overrun) ? rx_byte : hold_q;
        hold_vld_d = (byte_stb && !overrun) || (hold_vld_q && !consume);
        ferr_d     = stop_err || overrun;
        if (consume) begin
            case (state_q)
                S_SYNC: state_d = (hold_q == loader_sync_byte) ? S_CMD : S_SYNC;
                S_CMD: begin
                    state_d = (hold_q == loader_cmd_write) ? S_ADDR : S_SYNC;
                    boot_d  = boot_q || hold_q == loader_cmd_go;
                    cnt_d   = '0;
                end
                S_ADDR: begin
                    addr_d  = {hold_q, addr_q[31:8]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == 2'd3) ? S_DATA : S_ADDR;
                end
                S_DATA: begin
                    data_d  = {hold_q, data_q[31:8]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == 2'd3) ? data_done_state : S_DATA;
                end
                default: state_d = state_q;
            endcase
        end
`ifdef LOADER_CHECKSUM_EN
        chk_d = !consume ? chk_q : (state_q == S_CMD) ? hold_q : chk_q ^ hold_q;
        if (consume && state_q == S_CHK) begin
            state_d = (hold_q == chk_q) ? S_BUS : S_SYNC;
            ferr_d  = ferr_d || hold_q != chk_q;
        end
`endif
        if (state_q == S_BUS && mem_ready) state_d = S_SYNC;
        // A pending bus write always finishes; any line error elsewhere restarts framing
        if ((stop_err || overrun) && state_q != S_BUS) state_d = S_SYNC;
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and randomized UART packet streams checked against a packet-level model
module tb_uart_loader;
    import uart_loader_pkg::*;
    localparam int CPB = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam int PAY = 9;
`else
    localparam int PAY = 8;
`endif

    logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic mem_valid, mem_instr, boot_done, frame_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0] mem_wstrb;

    int n_chk = 0, n_err = 0;
    int ready_dly = 3;
    logic [7:0] sb[$];
    bit se[$];
    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    int got_len[$];
    int got_ferr = 0, exp_ferr = 0;
    logic exp_boot = 1'b0;

    always #5 clk = ~clk;

    uart_loader #(.CLK_PER_BIT(CPB)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .uart_rx   (uart_rx),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .boot_done (boot_done),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin : responder
        int v;
        v = 0;
        forever begin
            @(negedge clk);
            if (mem_valid && !mem_ready) begin
                v++;
                if (v >= ready_dly) mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
                v = 0;
            end
        end
    end

    logic [31:0] first_a, first_d;
    logic prev_v = 1'b0;
    int cur_len = 0;
    always @(negedge clk) begin
        if (frame_err) got_ferr++;
        if (mem_valid) begin
            check("wstrb", mem_wstrb, 4'hF);
            check("instr", mem_instr, 1'b0);
            if (!prev_v) begin
                first_a = mem_addr;
                first_d = mem_wdata;
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
                cur_len = 1;
            end else begin
                check("addr_stable", mem_addr, first_a);
                check("wdata_stable", mem_wdata, first_d);
                cur_len++;
            end
        end else if (prev_v) got_len.push_back(cur_len);
        prev_v = mem_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic [7:0] b, input bit bad = 1'b0);
        sb.push_back(b);
        se.push_back(bad);
    endtask

    task automatic put_write(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] x;
        x = loader_cmd_write;
        put(loader_sync_byte);
        put(loader_cmd_write);
        for (int k = 0; k < 4; k++) begin put(a[8*k +: 8]); x ^= a[8*k +: 8]; end
        for (int k = 0; k < 4; k++) begin put(d[8*k +: 8]); x ^= d[8*k +: 8]; end
        if (PAY == 9) put(x);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = !bad;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_all(input bit wait_done);
        int t;
        for (int k = 0; k < sb.size(); k++) send_byte(sb[k], se[k]);
        sb.delete();
        se.delete();
        if (wait_done) begin
            t = 0;
            while (mem_valid && t < 5000) begin @(negedge clk); t++; end
            check("bus_done_in_time", t < 5000, 1'b1);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        got_len.delete();
        exp_addr.delete();
        exp_data.delete();
        got_ferr = 0;
        exp_ferr = 0;
    endtask

    task automatic compare(input string p);
        check({p, "_nwrites"}, got_addr.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            check({p, "_addr"}, got_addr[k], exp_addr[k]);
            check({p, "_wdata"}, got_data[k], exp_data[k]);
        end
        check({p, "_frame_err"}, got_ferr, exp_ferr);
        check({p, "_boot_done"}, boot_done, exp_boot);
        clear_obs();
    endtask

    // Packet-level reading of the byte stream: what a correct loader must write
    task automatic run_model();
        int i, n;
        logic [7:0] p [PAY];
        logic [7:0] x;
        bit bad;
        i = 0;
        n = sb.size();
        while (i < n) begin
            if (se[i]) begin exp_ferr++; i++; end
            else if (sb[i] != loader_sync_byte || i + 1 >= n) i++;
            else if (se[i+1]) begin exp_ferr++; i += 2; end
            else if (sb[i+1] != loader_cmd_write) begin
                if (sb[i+1] == loader_cmd_go) exp_boot = 1'b1;
                i += 2;
            end else begin
                bad = 1'b0;
                for (int k = 0; k < PAY && !bad; k++) begin
                    if (i + 2 + k >= n) begin bad = 1'b1; i = n; end
                    else if (se[i+2+k]) begin bad = 1'b1; exp_ferr++; i = i + 3 + k; end
                    else p[k] = sb[i+2+k];
                end
                if (!bad) begin
                    x = loader_cmd_write;
                    for (int k = 0; k < 8; k++) x ^= p[k];
                    if (PAY == 9 && p[PAY-1] != x) exp_ferr++;
                    else begin
                        exp_addr.push_back({p[3], p[2], p[1], p[0]});
                        exp_data.push_back({p[7], p[6], p[5], p[4]});
                    end
                    i += 2 + PAY;
                end
            end
        end
    endtask

    initial begin
        int t;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst_valid", mem_valid, 1'b0);
        check("rst_wstrb", mem_wstrb, 4'h0);
        check("rst_instr", mem_instr, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_boot", boot_done, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        ready_dly = 3;
        put_write(32'h8001_0000, 32'hDEAD_BEEF);
        send_all(1'b1);
        check("t1_valid_cycles_seen", got_len.size(), 1);
        if (got_len.size() > 0) check("t1_valid_cycles", got_len[0], 3);
        exp_addr.push_back(32'h8001_0000);
        exp_data.push_back(32'hDEAD_BEEF);
        compare("t1");

        put(loader_sync_byte); put(loader_cmd_write); put(8'h00); put(8'h3C, 1'b1);
        put_write(32'h0000_0100, 32'h1234_5678);
        send_all(1'b1);
        exp_ferr = 1;
        exp_addr.push_back(32'h0000_0100);
        exp_data.push_back(32'h1234_5678);
        compare("t2");

        put(8'h00); put(8'hFF); put(8'h5A); put(loader_sync_byte); put(loader_cmd_go);
        send_all(1'b1);
        exp_boot = 1'b1;
        compare("t3");
        put_write(32'h0000_0200, 32'h0BAD_F00D);
        send_all(1'b1);
        exp_addr.push_back(32'h0000_0200);
        exp_data.push_back(32'h0BAD_F00D);
        compare("t3_after_go");

`ifdef LOADER_CHECKSUM_EN
        put_write(32'h0000_0010, 32'hA1B2_C3D4);
        put_write(32'h0000_0014, 32'h55AA_55AA);
        sb[sb.size()-1] ^= 8'h10;
        send_all(1'b1);
        exp_ferr = 1;
        exp_addr.push_back(32'h0000_0010);
        exp_data.push_back(32'hA1B2_C3D4);
        compare("t6");
`endif

        ready_dly = 40 * CPB;
        put_write(32'h0000_0300, 32'hCAFE_0001);
        put_write(32'h1234_5678, 32'h1122_3344);
        send_all(1'b1);
        exp_ferr = 2;
        exp_addr.push_back(32'h0000_0300);
        exp_data.push_back(32'hCAFE_0001);
        compare("t4_overrun");

        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 6; p++) begin
                t = $urandom_range(0, 2);
                for (int g = 0; g < t; g++) begin
                    b = 8'($urandom);
                    put(b == loader_sync_byte ? 8'h00 : b);
                end
                case ($urandom_range(0, 5))
                    0, 1: put_write($urandom, $urandom);
                    2: begin put(loader_sync_byte); put(loader_cmd_go); end
                    3: begin
                        b = 8'($urandom);
                        put(loader_sync_byte);
                        put((b == loader_cmd_write || b == loader_cmd_go) ? 8'h7E : b);
                    end
                    4: begin
                        put(loader_sync_byte);
                        t = $urandom_range(0, PAY);
                        if (t > 0) put(loader_cmd_write);
                        for (int k = 1; k < t; k++) put(8'($urandom));
                        put(8'($urandom), 1'b1);
                    end
                    default: begin
                        put_write($urandom, $urandom);
                        if (PAY == 9) sb[sb.size()-1] ^= 8'($urandom_range(1, 255));
                        else put(8'($urandom), 1'b1);
                    end
                endcase
            end
            ready_dly = $urandom_range(1, 5);
            run_model();
            send_all(1'b1);
            compare("rand");
        end

        ready_dly = 100000;
        put_write(32'h0000_0040, 32'hFACE_CAFE);
        send_all(1'b0);
        t = 0;
        while (!mem_valid && t < 1000) begin @(negedge clk); t++; end
        check("t5_valid_seen", mem_valid, 1'b1);
        check("t5_boot_before", boot_done, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid_async", mem_valid, 1'b0);
        check("t5_wstrb_async", mem_wstrb, 4'h0);
        check("t5_boot_cleared", boot_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready_dly = 2;
        exp_boot = 1'b0;
        repeat (2) @(negedge clk);
        clear_obs();
        put_write(32'h0000_0044, 32'h0102_0304);
        send_all(1'b1);
        exp_addr.push_back(32'h0000_0044);
        exp_data.push_back(32'h0102_0304);
        compare("t5_after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
